// File: rtl/anota_cfg_pkg.sv
// Shared types and constants for the anOTA host configuration port.
// Status register layout is {wr_cnt[3:0], err, 3'b000}.
package anota_cfg_pkg;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    localparam logic [AW-1:0] STATUS_ADDR = 4'hF;
    localparam int unsigned   WRCNT_MSB   = 7;
    localparam int unsigned   WRCNT_LSB   = 4;
    localparam int unsigned   ERR_BIT     = 3;
    localparam int unsigned   ERR_CLR_BIT = 3;

    function automatic logic [DW-1:0] status_byte(input logic [3:0] cnt, input logic err);
        logic [DW-1:0] s;
        s                       = '0;
        s[WRCNT_MSB:WRCNT_LSB]  = cnt;
        s[ERR_BIT]              = err;
        return s;
    endfunction

endpackage

// File: rtl/anota_cfg_port_if.sv
// Host pin bundle for the anOTA config port (req/ack 4-phase handshake).
// par_i exists only when ANOTA_CFG_PARITY_EN is defined.
interface anota_cfg_port_if;
    import anota_cfg_pkg::*;

    logic          req_i;
    logic          we_i;
    logic [AW-1:0] addr_i;
    logic [DW-1:0] wdata_i;
`ifdef ANOTA_CFG_PARITY_EN
    logic          par_i;
`endif
    logic          ack_o;
    logic [DW-1:0] rdata_o;
    logic          rdata_oe_o;

`ifdef ANOTA_CFG_PARITY_EN
    modport master (output req_i, we_i, addr_i, wdata_i, par_i,
                    input  ack_o, rdata_o, rdata_oe_o);
    modport slave  (input  req_i, we_i, addr_i, wdata_i, par_i,
                    output ack_o, rdata_o, rdata_oe_o);
`else
    modport master (output req_i, we_i, addr_i, wdata_i,
                    input  ack_o, rdata_o, rdata_oe_o);
    modport slave  (input  req_i, we_i, addr_i, wdata_i,
                    output ack_o, rdata_o, rdata_oe_o);
`endif

endinterface

// File: rtl/anota_sync.sv
// N-flop single-bit synchronizer, async active-high reset to 0.
module anota_sync #(
    parameter int unsigned N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [N-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[N-2:0], d_i};
    end

    assign q_o = sync_q[N-1];

endmodule

// File: rtl/anota_cfg_port.sv
// Host-side config responder: 4-phase req/ack register access to trim/bias bytes.
// Optional write parity checking with sticky error under ANOTA_CFG_PARITY_EN.
module anota_cfg_port
    import anota_cfg_pkg::*;
#(
    parameter int unsigned NREGS       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    anota_cfg_port_if.slave      bus,
    output logic [NREGS*8-1:0]   cfg_o
);

    localparam logic [AW-1:0] NREGS_A = AW'(NREGS);

    state_e        state_q, state_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] regs_q [NREGS];
    logic [DW-1:0] regs_d [NREGS];
    logic [3:0]    wr_cnt_q, wr_cnt_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          ack_q, ack_d;
    logic          oe_q, oe_d;
    logic          req_s;
    logic          par_ok_c;
    logic          err;

    anota_sync #(.N(SYNC_STAGES)) u_req_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus.req_i),
        .q_o (req_s)
    );

`ifdef ANOTA_CFG_PARITY_EN
    logic par_q, par_d;
    logic err_q, err_d;

    // Odd parity: XOR over the whole captured word including par must be 1.
    assign par_ok_c = ^{we_q, addr_q, wdata_q, par_q};
    assign err      = err_q;

    always_comb begin
        err_d = err_q;
        par_d = par_q;
        if (state_q == ST_IDLE && req_s) par_d = bus.par_i;
        if (state_q == ST_EXEC && we_q) begin
            if (!par_ok_c)                                           err_d = 1'b1;
            else if (addr_q == STATUS_ADDR && wdata_q[ERR_CLR_BIT]) err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            par_q <= par_d;
            err_q <= err_d;
        end
    end
`else
    assign par_ok_c = 1'b1;
    assign err      = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        regs_d   = regs_q;
        wr_cnt_d = wr_cnt_q;
        rdata_d  = rdata_q;
        ack_d    = 1'b0;
        oe_d     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    we_d    = bus.we_i;
                    addr_d  = bus.addr_i;
                    wdata_d = bus.wdata_i;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_ACK;
                ack_d   = 1'b1;
                oe_d    = ~we_q;
                if (we_q) begin
                    // Status and out-of-range addresses never touch the register file.
                    if (par_ok_c && addr_q < NREGS_A) begin
                        for (int i = 0; i < int'(NREGS); i++)
                            if (addr_q == AW'(i)) regs_d[i] = wdata_q;
                        wr_cnt_d = wr_cnt_q + 4'd1;
                    end
                end else begin
                    rdata_d = '0;
                    if (addr_q == STATUS_ADDR) rdata_d = status_byte(wr_cnt_q, err);
                    for (int i = 0; i < int'(NREGS); i++)
                        if (addr_q == AW'(i)) rdata_d = regs_q[i];
                end
            end
            ST_ACK: begin
                // Hold ack until the host releases req.
                if (req_s) begin
                    ack_d = 1'b1;
                    oe_d  = ~we_q;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
            wr_cnt_q <= '0;
            rdata_q  <= '0;
            ack_q    <= 1'b0;
            oe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            regs_q   <= regs_d;
            wr_cnt_q <= wr_cnt_d;
            rdata_q  <= rdata_d;
            ack_q    <= ack_d;
            oe_q     <= oe_d;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NREGS); i++) cfg_o[8*i +: 8] = regs_q[i];
    end

    assign bus.ack_o      = ack_q;
    assign bus.rdata_o    = rdata_q;
    assign bus.rdata_oe_o = oe_q;

endmodule
